pll_cfg_sequencer: RTL and testbench
====================================

# pll_cfg_sequencer

Runtime reconfiguration sequencer for the Cyclone V fractional PLL wrappers, parametrised in output-clock count. It accepts a complete PLL setting (N, M, fractional K and one C divider per output) over a valid/ready request port. It then replays that setting as Avalon-MM writes into the PLL reconfiguration controller, which drives the PLL's 64-bit reconfig bus, and waits for the PLL to relock. It sits beside the clock-generation PLL and lets the core switch video or system clock modes without a new bitstream.

## Interface
Parameters:
- NUM_OUT, 2, number of C counters written per request, legal range 1..18
- SETTLE, 16, cycles during which pll_locked is ignored after START is accepted
- LOCK_TIMEOUT, 65535, maximum cycles to wait for pll_locked=1 after SETTLE

Ports:
- Clock and reset: single clock `refclk`; reset `rst_n`, asynchronous, active-low.
- refclk  in  1  management clock (50 MHz); all logic is in this domain
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  request strobe
- cfg_ready  out  1  sequencer idle and able to accept a request
- cfg_n  in  18  N counter word: [17] odd-duty, [16] bypass, [15:8] hi, [7:0] lo
- cfg_m  in  18  M counter word, same format as cfg_n
- cfg_k  in  32  fractional K value
- cfg_c  in  18*NUM_OUT  C counter words; slice i is bits [18*i+17:18*i]
- mgmt_address  out  6  Avalon-MM word address
- mgmt_write  out  1  Avalon-MM write
- mgmt_writedata  out  32  Avalon-MM write data
- mgmt_waitrequest  in  1  Avalon-MM stall
- pll_locked  in  1  PLL lock, already synchronised to refclk
- busy  out  1  high from request accept to completion
- done  out  1  one-cycle pulse at completion, whether success or timeout
- err  out  1  lock timeout flag; sticky until the next accepted request

## Operation
- A request is accepted on a cycle where cfg_valid=1 and cfg_ready=1.
  - All cfg_* fields are captured into registers on that edge; later input changes have no effect.
  - err clears on that same edge.
- cfg_ready = (state==IDLE), decoded combinationally from state.
- FSM states, in order:
  - IDLE
  - WR_MODE: address 0x00, data 0 (waitrequest mode)
  - WR_N: address 0x03, data {14'b0, n}
  - WR_M: address 0x04, data {14'b0, m}
  - WR_C: address 0x05, data {9'b0, idx[4:0], c[idx]}; repeats for idx = 0..NUM_OUT-1
  - WR_K: address 0x07, data k
  - WR_START: address 0x02, data 0
  - SETTLE
  - LOCK
  - DONE
  - DONE returns to IDLE.
- Write handshake:
  - In each WR_* state, mgmt_write=1 and address/data are held stable.
  - The write completes on the rising edge where mgmt_waitrequest=0; the FSM advances on that same edge.
  - There is no cycle of mgmt_write=0 between consecutive writes.
- SETTLE: a counter runs SETTLE cycles, then the FSM goes to LOCK.
- LOCK:
  - pll_locked=1 -> DONE with err=0.
  - After LOCK_TIMEOUT cycles without lock -> DONE with err=1.
- Outside WR_* states: mgmt_write=0, mgmt_address=0, mgmt_writedata=0.

## Timing
- Reset values: cfg_ready=1, busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, FSM in IDLE.
- Reset asserted mid-operation:
  - Everything returns to reset values immediately, including mgmt_write.
  - An aborted transfer is acceptable because the reconfig controller shares rst_n.
- Throughput with zero waitrequest:
  - Accept at cycle 0; mgmt_write high in cycles 1 .. 5+NUM_OUT (5+NUM_OUT writes).
  - SETTLE occupies the next SETTLE cycles.
  - With pll_locked already 1, done pulses 2 cycles after SETTLE ends (the LOCK cycle, then DONE).
- Each waitrequest cycle extends the sequence by exactly one cycle.
- busy rises the cycle after accept and falls in the cycle done pulses.
- cfg_valid while busy is ignored; no queuing.
- pll_locked toggling during WR_* or SETTLE is ignored.
- Timeout and lock in the same cycle: lock wins, err=0.
- Counter widths:
  - The C index counter is 5 bits.
  - The SETTLE and LOCK counters are sized by $clog2 of their parameter plus 1; there is no wrap-around inside a phase.

## Structure
- Shared package pll_cfg_pkg holds:
  - Address constants ADDR_MODE/START/N/M/C/K
  - Counter-word width (18) and C index width (5)
  - The FSM state enum
- One natural sub-module: pll_cfg_avmm_wr. It is a single-write engine holding address/data/write until waitrequest drops, and returns a one-cycle ack to the FSM.
- Elaboration check: NUM_OUT outside 1..18 is a fatal error.

## Test plan
- NUM_OUT=2, waitrequest tied 0, locked=1, request n=0x10000 m=0x00504 k=0xAAC8_2E34 c0=0x20302 c1=0x00505:
  - Exactly 7 writes to addresses 0,3,4,5,5,7,2.
  - C data 0x00020302 then 0x00040505.
  - done at cycle 7+SETTLE+2, err=0.
- Random 0–3 cycle waitrequest stalls on every write -> identical write sequence, each beat held stable until accepted, total latency grows by the stall count.
- pll_locked held 0 -> done after SETTLE+LOCK_TIMEOUT cycles, err=1. A following request clears err on accept.
- cfg_valid pulsed while busy with different data -> ignored; the original sequence completes unchanged.
- rst_n asserted during WR_C -> mgmt_write, busy and done go 0 asynchronously. After release, cfg_ready=1 and a new request runs the full sequence.
- NUM_OUT=18 -> 23 writes, last C beat carries index 17 (data bits [22:18]=5'd17).

Source files
------------

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
// Holds the reconfig-controller register map, counter-word widths and the FSM state type.
// No logic of its own; imported by pll_cfg_sequencer and pll_cfg_avmm_wr.
package pll_cfg_pkg;

   localparam int CW_W   = 18;  // PLL counter word: {odd, bypass, hi[7:0], lo[7:0]}
   localparam int CIDX_W = 5;   // C counter select field in the C write word
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'h00;
   localparam logic [ADDR_W-1:0] ADDR_START = 6'h02;
   localparam logic [ADDR_W-1:0] ADDR_N     = 6'h03;
   localparam logic [ADDR_W-1:0] ADDR_M     = 6'h04;
   localparam logic [ADDR_W-1:0] ADDR_C     = 6'h05;
   localparam logic [ADDR_W-1:0] ADDR_K     = 6'h07;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_MODE,
      S_WR_N,
      S_WR_M,
      S_WR_C,
      S_WR_K,
      S_WR_START,
      S_SETTLE,
      S_LOCK,
      S_DONE
   } state_e;

   function automatic logic is_wr_state(input state_e s);
      return (s inside {S_WR_MODE, S_WR_N, S_WR_M, S_WR_C, S_WR_K, S_WR_START});
   endfunction

endpackage

// File: rtl/pll_cfg_avmm_wr.sv
// Single-beat Avalon-MM write engine: presents one address/data word until it is accepted.
// Latency: zero; bus signals follow req_vld_i combinationally, ack_o on the accepting cycle.
// Backpressure: mgmt_waitrequest_i stalls the beat; the requester holds the request until ack_o.
// Ports: req_vld_i/req_addr_i/req_dat_i (beat from FSM), ack_o (beat accepted this edge),
//        mgmt_* (Avalon-MM master side toward the reconfig controller).
module pll_cfg_avmm_wr
   import pll_cfg_pkg::*;
(
   input  logic              req_vld_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_dat_i,
   output logic              ack_o,
   output logic [ADDR_W-1:0] mgmt_address_o,
   output logic              mgmt_write_o,
   output logic [DATA_W-1:0] mgmt_writedata_o,
   input  logic              mgmt_waitrequest_i
);

   // Bus is forced to zero whenever no beat is pending.
   assign mgmt_write_o     = req_vld_i;
   assign mgmt_address_o   = req_vld_i ? req_addr_i : '0;
   assign mgmt_writedata_o = req_vld_i ? req_dat_i  : '0;
   assign ack_o            = req_vld_i & ~mgmt_waitrequest_i;

endmodule

// File: rtl/pll_cfg_sequencer.sv
// Replays a captured PLL setting as Avalon-MM writes into the reconfig controller, then waits for relock.
// Latency: 5+NUM_OUT write cycles (plus waitrequest stalls), SETTLE cycles, lock wait, one DONE cycle.
// Backpressure: cfg_ready only in IDLE (no queuing); mgmt_waitrequest stretches the current write.
// Ports: refclk/rst_n; cfg_valid/cfg_ready + cfg_n/m/k/c request; mgmt_* Avalon-MM master;
//        pll_locked (synchronised); busy/done/err status.
module pll_cfg_sequencer
   import pll_cfg_pkg::*;
#(
   parameter int NUM_OUT      = 2,
   parameter int SETTLE       = 16,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic                    refclk,
   input  logic                    rst_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CW_W-1:0]         cfg_n,
   input  logic [CW_W-1:0]         cfg_m,
   input  logic [31:0]             cfg_k,
   input  logic [CW_W*NUM_OUT-1:0] cfg_c,
   output logic [ADDR_W-1:0]       mgmt_address,
   output logic                    mgmt_write,
   output logic [DATA_W-1:0]       mgmt_writedata,
   input  logic                    mgmt_waitrequest,
   input  logic                    pll_locked,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   if (NUM_OUT < 1 || NUM_OUT > 18) begin : g_num_out_chk
      $fatal(1, "pll_cfg_sequencer: NUM_OUT=%0d outside 1..18", NUM_OUT);
   end

   // One counter serves both SETTLE and LOCK phases; sized for the larger of the two.
   localparam int SET_W = $clog2(SETTLE) + 1;
   localparam int LCK_W = $clog2(LOCK_TIMEOUT) + 1;
   localparam int CNT_W = (SET_W > LCK_W) ? SET_W : LCK_W;

   state_e                    state_q, state_d;
   logic [CW_W-1:0]           n_q, m_q;
   logic [31:0]               k_q;
   logic [CW_W*NUM_OUT-1:0]   c_q;
   logic [CIDX_W-1:0]         idx_q, idx_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      err_q, err_d;

   logic                      accept;
   logic                      wr_vld, wr_ack;
   logic [ADDR_W-1:0]         wr_addr;
   logic [DATA_W-1:0]         wr_dat;
   logic [CW_W-1:0]           c_sel;
   logic                      idx_last, settle_end, lock_tmo;

   assign accept     = cfg_valid && (state_q == S_IDLE);
   assign c_sel      = c_q[int'(idx_q)*CW_W +: CW_W];
   assign idx_last   = (idx_q == CIDX_W'(NUM_OUT - 1));
   assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));
   assign lock_tmo   = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

   // State register
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (accept) state_d = S_WR_MODE;
         S_WR_MODE:  if (wr_ack) state_d = S_WR_N;
         S_WR_N:     if (wr_ack) state_d = S_WR_M;
         S_WR_M:     if (wr_ack) state_d = S_WR_C;
         S_WR_C:     if (wr_ack && idx_last) state_d = S_WR_K;
         S_WR_K:     if (wr_ack) state_d = S_WR_START;
         S_WR_START: if (wr_ack) state_d = S_SETTLE;
         S_SETTLE:   if (settle_end) state_d = S_LOCK;
         // Lock is tested before the timeout so a coincident lock wins.
         S_LOCK:     if (pll_locked || lock_tmo) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath next-state: C index, phase counter, sticky error
   always_comb begin
      idx_d = idx_q;
      if (accept)
         idx_d = '0;
      else if (state_q == S_WR_C && wr_ack && !idx_last)
         idx_d = idx_q + 1'b1;

      // Counter restarts at zero on every phase change, so it never wraps within a phase.
      cnt_d = '0;
      if ((state_q == S_SETTLE || state_q == S_LOCK) && state_d == state_q)
         cnt_d = cnt_q + 1'b1;

      err_d = err_q;
      if (accept)
         err_d = 1'b0;
      else if (state_q == S_LOCK && !pll_locked && lock_tmo)
         err_d = 1'b1;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         n_q   <= '0;
         m_q   <= '0;
         k_q   <= '0;
         c_q   <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            n_q <= cfg_n;
            m_q <= cfg_m;
            k_q <= cfg_k;
            c_q <= cfg_c;
         end
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Output decode
   always_comb begin
      wr_vld  = is_wr_state(state_q);
      wr_addr = '0;
      wr_dat  = '0;
      case (state_q)
         S_WR_MODE:  wr_addr = ADDR_MODE;
         S_WR_N:     begin wr_addr = ADDR_N; wr_dat = {14'b0, n_q};         end
         S_WR_M:     begin wr_addr = ADDR_M; wr_dat = {14'b0, m_q};         end
         S_WR_C:     begin wr_addr = ADDR_C; wr_dat = {9'b0, idx_q, c_sel}; end
         S_WR_K:     begin wr_addr = ADDR_K; wr_dat = k_q;                  end
         S_WR_START: wr_addr = ADDR_START;
         default:    ;
      endcase
   end

   assign cfg_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

   pll_cfg_avmm_wr u_wr (
      .req_vld_i          (wr_vld),
      .req_addr_i         (wr_addr),
      .req_dat_i          (wr_dat),
      .ack_o              (wr_ack),
      .mgmt_address_o     (mgmt_address),
      .mgmt_write_o       (mgmt_write),
      .mgmt_writedata_o   (mgmt_writedata),
      .mgmt_waitrequest_i (mgmt_waitrequest)
   );

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Directed bench for pll_cfg_sequencer: a NUM_OUT=2 instance and a NUM_OUT=18 instance.
module tb_pll_cfg_sequencer;

   localparam int NO_A = 2,  SET_A = 16, LT_A = 40;
   localparam int NO_B = 18, SET_B = 4,  LT_B = 8;

   logic                refclk = 1'b0;
   logic                rst_n  = 1'b1;
   logic                cfg_valid = 1'b0;
   logic                cfg_ready;
   logic [17:0]         cfg_n = '0, cfg_m = '0;
   logic [31:0]         cfg_k = '0;
   logic [18*NO_A-1:0]  cfg_c = '0;
   logic [5:0]          mgmt_address;
   logic                mgmt_write;
   logic [31:0]         mgmt_writedata;
   logic                mgmt_waitrequest = 1'b0;
   logic                pll_locked = 1'b1;
   logic                busy, done, err;

   logic                cfg_valid18 = 1'b0;
   logic                cfg_ready18;
   logic [18*NO_B-1:0]  cfg_c18 = '0;
   logic [5:0]          addr18;
   logic                write18;
   logic [31:0]         data18;
   logic                wreq18 = 1'b0;
   logic                busy18, done18, err18;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc    = 0;
   int at     = 0;

   always #5 refclk = ~refclk;
   always @(posedge refclk) cyc <= cyc + 1;

   pll_cfg_sequencer #(.NUM_OUT(NO_A), .SETTLE(SET_A), .LOCK_TIMEOUT(LT_A)) dut (
      .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c),
      .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
      .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
      .busy(busy), .done(done), .err(err)
   );

   pll_cfg_sequencer #(.NUM_OUT(NO_B), .SETTLE(SET_B), .LOCK_TIMEOUT(LT_B)) dut18 (
      .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid18), .cfg_ready(cfg_ready18),
      .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c18),
      .mgmt_address(addr18), .mgmt_write(write18), .mgmt_writedata(data18),
      .mgmt_waitrequest(wreq18), .pll_locked(pll_locked),
      .busy(busy18), .done(done18), .err(err18)
   );

   // Waitrequest generator: each beat gets 0..3 stall cycles when enabled.
   bit stall_en   = 1'b0;
   int stall_left = 0;
   bit new_beat   = 1'b1;
   always @(posedge refclk) begin
      #1;
      if (stall_en && mgmt_write) begin
         if (new_beat) stall_left = $urandom_range(0, 3);
         mgmt_waitrequest = (stall_left != 0);
         if (stall_left != 0) stall_left--;
         new_beat = !mgmt_waitrequest;
      end else begin
         mgmt_waitrequest = 1'b0;
         new_beat = 1'b1;
      end
   end

   // Bus monitor, sampled mid-cycle.
   logic [5:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   int          stalls = 0, stab_viol = 0, done_cnt = 0;
   bit          prev_hold = 1'b0;
   logic [5:0]  prev_a = '0;
   logic [31:0] prev_d = '0;
   int          b_wr = 0, b_cwr = 0;
   logic [31:0] b_last_c = '0;

   always @(negedge refclk) begin
      if (mgmt_write && !mgmt_waitrequest) begin
         wa_q.push_back(mgmt_address);
         wd_q.push_back(mgmt_writedata);
         wc_q.push_back(cyc);
      end
      if (mgmt_write && mgmt_waitrequest) stalls++;
      if (prev_hold && !(mgmt_write && mgmt_address == prev_a && mgmt_writedata == prev_d))
         stab_viol++;
      prev_hold = mgmt_write && mgmt_waitrequest;
      prev_a    = mgmt_address;
      prev_d    = mgmt_writedata;
      if (done) done_cnt++;
      if (write18 && !wreq18) begin
         b_wr++;
         if (addr18 == 6'h05) begin
            b_cwr++;
            b_last_c = data18;
         end
      end
   end

   logic [31:0] exp_a [7];
   logic [31:0] exp_d [7];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
      stalls = 0; stab_viol = 0; done_cnt = 0;
   endtask

   task automatic send_req(input logic [17:0] n, input logic [17:0] m, input logic [31:0] k,
                           input logic [17:0] c0, input logic [17:0] c1);
      @(posedge refclk); #1;
      cfg_n = n; cfg_m = m; cfg_k = k; cfg_c = {c1, c0};
      cfg_valid = 1'b1;
      acc = cyc;
      @(posedge refclk); #1;
      cfg_valid = 1'b0;
      // Scramble inputs after accept; the captured setting must be used.
      cfg_n = '1; cfg_m = '1; cfg_k = '1; cfg_c = '1;
   endtask

   task automatic wait_done(input int maxc, input string tag);
      bit got;
      got = 1'b0;
      at  = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge refclk);
         if (done) begin
            got = 1'b1;
            at  = cyc;
            break;
         end
      end
      chk(tag, 32'(got), 32'd1);
      #1;
   endtask

   task automatic check_seq(input string pfx);
      chk({pfx, "_nwr"}, wa_q.size(), 32'd7);
      for (int i = 0; i < 7; i++) begin
         if (i < wa_q.size()) begin
            chk($sformatf("%s_addr%0d", pfx, i), 32'(wa_q[i]), exp_a[i]);
            chk($sformatf("%s_data%0d", pfx, i), wd_q[i], exp_d[i]);
         end
      end
   endtask

   initial begin
      exp_a = '{32'h0, 32'h3, 32'h4, 32'h5, 32'h5, 32'h7, 32'h2};
      exp_d = '{32'h0, 32'h0001_0000, 32'h0000_0504, 32'h0002_0302,
                32'h0004_0505, 32'hAAC8_2E34, 32'h0};

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(negedge refclk);
      chk("rst_ready",  32'(cfg_ready), 32'd1);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_err",    32'(err), 32'd0);
      chk("rst_write",  32'(mgmt_write), 32'd0);
      chk("rst_addr",   32'(mgmt_address), 32'd0);
      chk("rst_data",   mgmt_writedata, 32'd0);
      chk("rst_ready18", 32'(cfg_ready18), 32'd1);
      @(posedge refclk); #2 rst_n = 1'b1;

      // T1: nominal sequence, no stalls, locked
      clear_mon();
      send_req(18'h10000, 18'h00504, 32'hAAC8_2E34, 18'h20302, 18'h00505);
      @(negedge refclk);
      chk("t1_busy_rise", 32'(busy), 32'd1);
      chk("t1_ready_low", 32'(cfg_ready), 32'd0);
      wait_done(60, "t1_done_seen");
      chk("t1_latency", at - acc, 32'(9 + SET_A));
      chk("t1_busy_at_done", 32'(busy), 32'd0);
      chk("t1_err", 32'(err), 32'd0);
      check_seq("t1");
      for (int i = 0; i < 7; i++)
         if (i < wc_q.size()) chk($sformatf("t1_wcyc%0d", i), wc_q[i] - acc, 32'(i + 1));
      chk("t1_done_pulses", done_cnt, 32'd1);

      // T2: random waitrequest stalls
      stall_en = 1'b1;
      clear_mon();
      send_req(18'h10000, 18'h00504, 32'hAAC8_2E34, 18'h20302, 18'h00505);
      wait_done(120, "t2_done_seen");
      chk("t2_latency", at - acc, 32'(9 + SET_A + stalls));
      check_seq("t2");
      chk("t2_stable", stab_viol, 32'd0);
      stall_en = 1'b0;

      // T3: lock timeout, with pll_locked toggling during writes/settle
      clear_mon();
      send_req(18'h10000, 18'h00504, 32'hAAC8_2E34, 18'h20302, 18'h00505);
      repeat (20) begin
         @(posedge refclk); #1;
         pll_locked = ~pll_locked;
      end
      pll_locked = 1'b0;
      wait_done(120, "t3_done_seen");
      chk("t3_latency", at - acc, 32'(8 + SET_A + LT_A));
      chk("t3_err_at_done", 32'(err), 32'd1);
      repeat (3) @(negedge refclk);
      chk("t3_err_sticky", 32'(err), 32'd1);
      chk("t3_ready", 32'(cfg_ready), 32'd1);
      pll_locked = 1'b1;

      // T3b: next request clears err on accept
      clear_mon();
      send_req(18'h10000, 18'h00504, 32'hAAC8_2E34, 18'h20302, 18'h00505);
      @(negedge refclk);
      chk("t3b_err_clear", 32'(err), 32'd0);
      wait_done(60, "t3b_done_seen");
      chk("t3b_err", 32'(err), 32'd0);
      chk("t3b_latency", at - acc, 32'(9 + SET_A));

      // T4: cfg_valid while busy is ignored
      clear_mon();
      send_req(18'h10000, 18'h00504, 32'hAAC8_2E34, 18'h20302, 18'h00505);
      repeat (2) @(posedge refclk);
      #1;
      cfg_n = 18'h30303; cfg_m = 18'h01111; cfg_k = 32'h1234_5678; cfg_c = '0;
      cfg_valid = 1'b1;
      repeat (2) @(posedge refclk);
      #1 cfg_valid = 1'b0;
      wait_done(60, "t4_done_seen");
      chk("t4_latency", at - acc, 32'(9 + SET_A));
      check_seq("t4");
      repeat (3) @(negedge refclk);
      chk("t4_idle_ready", 32'(cfg_ready), 32'd1);
      chk("t4_idle_busy", 32'(busy), 32'd0);
      chk("t4_done_pulses", done_cnt, 32'd1);

      // T5: reset asserted during WR_C
      clear_mon();
      send_req(18'h10000, 18'h00504, 32'hAAC8_2E34, 18'h20302, 18'h00505);
      repeat (3) @(posedge refclk);
      @(negedge refclk);
      chk("t5_in_wr_c_addr", 32'(mgmt_address), 32'h5);
      chk("t5_in_wr_c_data", mgmt_writedata, 32'h0002_0302);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_write", 32'(mgmt_write), 32'd0);
      chk("t5_rst_busy",  32'(busy), 32'd0);
      chk("t5_rst_done",  32'(done), 32'd0);
      chk("t5_rst_ready", 32'(cfg_ready), 32'd1);
      chk("t5_rst_addr",  32'(mgmt_address), 32'd0);
      @(posedge refclk); #2 rst_n = 1'b1;
      clear_mon();
      send_req(18'h10000, 18'h00504, 32'hAAC8_2E34, 18'h20302, 18'h00505);
      wait_done(60, "t5_done_seen");
      chk("t5_latency", at - acc, 32'(9 + SET_A));
      check_seq("t5");

      // T6: NUM_OUT=18 instance
      b_wr = 0; b_cwr = 0;
      @(posedge refclk); #1;
      cfg_n = 18'h10000; cfg_m = 18'h00504; cfg_k = 32'hAAC8_2E34;
      for (int i = 0; i < NO_B; i++) cfg_c18[i*18 +: 18] = 18'h00100 + 18'(i);
      cfg_valid18 = 1'b1;
      acc = cyc;
      @(posedge refclk); #1;
      cfg_valid18 = 1'b0;
      begin
         bit got18;
         got18 = 1'b0;
         at = -1;
         for (int i = 0; i < 80; i++) begin
            @(negedge refclk);
            if (done18) begin
               got18 = 1'b1;
               at = cyc;
               break;
            end
         end
         chk("t6_done_seen", 32'(got18), 32'd1);
      end
      #1;
      chk("t6_nwr", b_wr, 32'd23);
      chk("t6_ncwr", b_cwr, 32'd18);
      chk("t6_last_c", b_last_c, 32'h0044_0111);
      chk("t6_latency", at - acc, 32'(5 + NO_B + SET_B + 2));
      chk("t6_err", 32'(err18), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
